// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with optional skid entry.
// Empty slots always present a NOP instruction and zero payload.
module pipe_stage_elastic #(
    parameter int unsigned          DATA_W    = 106,
    parameter int unsigned          INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(32'h00000013),
    parameter int unsigned          DEPTH     = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_W-1:0]  o_data,
    output logic [INSTR_W-1:0] o_instr,
    output logic [1:0]         o_count
);

    generate
        if (DEPTH != 1 && DEPTH != 2) begin : g_bad_depth
            $error("pipe_stage_elastic: DEPTH must be 1 or 2");
        end
    endgenerate

    logic               head_valid;
    logic [DATA_W-1:0]  head_data;
    logic [INSTR_W-1:0] head_instr;
    logic               skid_valid;
    logic [DATA_W-1:0]  skid_data;
    logic [INSTR_W-1:0] skid_instr;
    logic [1:0]         count_q;

    logic               head_valid_nxt;
    logic [DATA_W-1:0]  head_data_nxt;
    logic [INSTR_W-1:0] head_instr_nxt;
    logic               skid_valid_nxt;
    logic [DATA_W-1:0]  skid_data_nxt;
    logic [INSTR_W-1:0] skid_instr_nxt;
    logic [1:0]         count_nxt;

    logic               push;
    logic               pop;

    // Depth 1 passes ready through; depth 2 derives it from the skid flop only.
    generate
        if (DEPTH == 2) begin : g_ready_skid
            assign o_ready = ~skid_valid;
        end else begin : g_ready_reg
            assign o_ready = ~head_valid | i_ready;
        end
    endgenerate

    assign push    = i_valid & o_ready;
    assign pop     = head_valid & i_ready;
    assign o_valid = head_valid;
    assign o_data  = head_data;
    assign o_instr = head_instr;
    assign o_count = count_q;

    // Next-state: flush beats pop, pop beats push; skid drains into head first.
    always_comb begin
        head_valid_nxt = head_valid;
        head_data_nxt  = head_data;
        head_instr_nxt = head_instr;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        skid_instr_nxt = skid_instr;
        if (i_flush) begin
            head_valid_nxt = 1'b0;
            head_data_nxt  = '0;
            head_instr_nxt = NOP_INSTR;
            skid_valid_nxt = 1'b0;
            skid_data_nxt  = '0;
            skid_instr_nxt = NOP_INSTR;
        end else if (pop) begin
            if (skid_valid) begin
                head_valid_nxt = 1'b1;
                head_data_nxt  = skid_data;
                head_instr_nxt = skid_instr;
                skid_valid_nxt = 1'b0;
                skid_data_nxt  = '0;
                skid_instr_nxt = NOP_INSTR;
            end else if (push) begin
                head_valid_nxt = 1'b1;
                head_data_nxt  = i_data;
                head_instr_nxt = i_instr;
            end else begin
                head_valid_nxt = 1'b0;
                head_data_nxt  = '0;
                head_instr_nxt = NOP_INSTR;
            end
        end else if (push) begin
            if (!head_valid) begin
                head_valid_nxt = 1'b1;
                head_data_nxt  = i_data;
                head_instr_nxt = i_instr;
            end else if (DEPTH == 2) begin
                skid_valid_nxt = 1'b1;
                skid_data_nxt  = i_data;
                skid_instr_nxt = i_instr;
            end
        end
        count_nxt = {1'b0, head_valid_nxt} + {1'b0, skid_valid_nxt};
    end

    // State registers; reset empties both slots immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_valid <= 1'b0;
            head_data  <= '0;
            head_instr <= NOP_INSTR;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_instr <= NOP_INSTR;
            count_q    <= 2'd0;
        end else begin
            head_valid <= head_valid_nxt;
            head_data  <= head_data_nxt;
            head_instr <= head_instr_nxt;
            skid_valid <= skid_valid_nxt;
            skid_data  <= skid_data_nxt;
            skid_instr <= skid_instr_nxt;
            count_q    <= count_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: DEPTH=1 (index 0) and DEPTH=2 (index 1).
// Directed vectors plus a queue-model driven random phase.
module tb_pipe_stage_elastic;

    localparam logic [31:0] NOP = 32'h00000013;

    logic         clk;
    logic         rst_n;
    logic         vld  [2];
    logic         rdy  [2];
    logic         fl   [2];
    logic [105:0] din  [2];
    logic [31:0]  iin  [2];
    logic         ordy [2];
    logic         ovld [2];
    logic [105:0] dout [2];
    logic [31:0]  iout [2];
    logic [1:0]   cnt  [2];

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage_elastic #(.DEPTH(1)) u_d1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(vld[0]), .o_ready(ordy[0]),
        .i_data(din[0]), .i_instr(iin[0]),
        .i_flush(fl[0]), .o_valid(ovld[0]),
        .i_ready(rdy[0]), .o_data(dout[0]),
        .o_instr(iout[0]), .o_count(cnt[0])
    );

    pipe_stage_elastic #(.DEPTH(2)) u_d2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(vld[1]), .o_ready(ordy[1]),
        .i_data(din[1]), .i_instr(iin[1]),
        .i_flush(fl[1]), .o_valid(ovld[1]),
        .i_ready(rdy[1]), .o_data(dout[1]),
        .o_instr(iout[1]), .o_count(cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream must hold a stalled entry unless it is flushed away.
    for (genvar g = 0; g < 2; g++) begin : g_proto
        assert property (@(posedge clk) disable iff (!rst_n)
            (vld[g] && !ordy[g] && !fl[g]) |=>
            (vld[g] && $stable(din[g]) && $stable(iin[g])));
    end

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int k, input logic v,
                         input logic [105:0] d, input logic [31:0] ins,
                         input logic r, input logic f);
        vld[k] = v;
        din[k] = d;
        iin[k] = ins;
        rdy[k] = r;
        fl[k]  = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input int k, input string tag);
        check({tag, ".valid"}, 128'(ovld[k]), 128'(0));
        check({tag, ".instr"}, 128'(iout[k]), 128'(NOP));
        check({tag, ".data"},  128'(dout[k]), 128'(0));
        check({tag, ".count"}, 128'(cnt[k]),  128'(0));
    endtask

    task automatic rand_phase(input int k, input int cycles);
        logic [105:0] q_d [$];
        logic [31:0]  q_i [$];
        logic hold;
        logic push, pop;
        logic [105:0] nd;
        hold = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            nd = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (!hold) begin
                vld[k] = ($urandom_range(3) != 0);
                din[k] = nd;
                iin[k] = $urandom();
            end
            rdy[k] = ($urandom_range(2) != 0);
            fl[k]  = ($urandom_range(24) == 0);
            #1;
            push = vld[k] && ordy[k];
            pop  = ovld[k] && rdy[k];
            hold = vld[k] && !ordy[k] && !fl[k];
            if (fl[k]) begin
                q_d.delete();
                q_i.delete();
            end else begin
                if (pop && q_d.size() > 0) begin
                    void'(q_d.pop_front());
                    void'(q_i.pop_front());
                end
                if (push) begin
                    q_d.push_back(din[k]);
                    q_i.push_back(iin[k]);
                end
            end
            tick();
            check("rnd.count", 128'(cnt[k]), 128'(q_d.size()));
            check("rnd.valid", 128'(ovld[k]), 128'(q_d.size() != 0));
            if (q_d.size() != 0) begin
                check("rnd.data",  128'(dout[k]), 128'(q_d[0]));
                check("rnd.instr", 128'(iout[k]), 128'(q_i[0]));
            end else begin
                check("rnd.data",  128'(dout[k]), 128'(0));
                check("rnd.instr", 128'(iout[k]), 128'(NOP));
            end
            if (k == 1)
                check("rnd.ready", 128'(ordy[k]), 128'(q_d.size() < 2));
        end
        drive(k, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) drive(k, 1'b0, '0, '0, 1'b0, 1'b0);
        #12;
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 2; k++) begin
            chk_empty(k, "rst");
            check("rst.ready", 128'(ordy[k]), 128'(1));
        end

        // Single pass-through on DEPTH=1
        drive(0, 1'b1, 106'd5, 32'h00A00093, 1'b1, 1'b0);
        tick();
        check("t1.valid", 128'(ovld[0]), 128'(1));
        check("t1.instr", 128'(iout[0]), 128'(32'h00A00093));
        check("t1.data",  128'(dout[0]), 128'(5));
        check("t1.count", 128'(cnt[0]),  128'(1));
        drive(0, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        chk_empty(0, "t1.drain");

        // DEPTH=2 stall into skid, then drain
        drive(1, 1'b1, 106'd1, 32'h00100093, 1'b0, 1'b0);
        tick();
        check("t2.cnt1",  128'(cnt[1]),  128'(1));
        check("t2.rdy1",  128'(ordy[1]), 128'(1));
        check("t2.data1", 128'(dout[1]), 128'(1));
        drive(1, 1'b1, 106'd2, 32'h00200093, 1'b0, 1'b0);
        tick();
        check("t2.cnt2",  128'(cnt[1]),  128'(2));
        check("t2.rdy2",  128'(ordy[1]), 128'(0));
        check("t2.data2", 128'(dout[1]), 128'(1));
        check("t2.instr", 128'(iout[1]), 128'(32'h00100093));
        drive(1, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        check("t2.popA.data",  128'(dout[1]), 128'(2));
        check("t2.popA.instr", 128'(iout[1]), 128'(32'h00200093));
        check("t2.popA.cnt",   128'(cnt[1]),  128'(1));
        check("t2.popA.rdy",   128'(ordy[1]), 128'(1));
        tick();
        chk_empty(1, "t2.popB");
        check("t2.popB.rdy", 128'(ordy[1]), 128'(1));

        // Back-to-back stream, both depths
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                drive(k, 1'b1, 106'(100 + i), 32'(i), 1'b1, 1'b0);
                #1;
                check("t3.acc", 128'(ordy[k]), 128'(1));
                tick();
                check("t3.valid", 128'(ovld[k]), 128'(1));
                check("t3.data",  128'(dout[k]), 128'(100 + i));
                check("t3.instr", 128'(iout[k]), 128'(i));
            end
            drive(k, 1'b0, '0, '0, 1'b1, 1'b0);
            tick();
            chk_empty(k, "t3.end");
        end

        // Flush while DEPTH=2 is full with a same-cycle push
        drive(1, 1'b1, 106'd1, 32'h1, 1'b0, 1'b0);
        tick();
        drive(1, 1'b1, 106'd2, 32'h2, 1'b0, 1'b0);
        tick();
        check("t4.full", 128'(cnt[1]), 128'(2));
        drive(1, 1'b1, 106'd7, 32'h7, 1'b0, 1'b1);
        tick();
        chk_empty(1, "t4.flush");
        check("t4.rdy", 128'(ordy[1]), 128'(1));
        drive(1, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        chk_empty(1, "t4.after");

        // Async reset in mid-cycle
        drive(0, 1'b1, 106'd9, 32'h9, 1'b0, 1'b0);
        tick();
        check("t5.held", 128'(cnt[0]), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_empty(0, "t5.arst");
        check("t5.rdy", 128'(ordy[0]), 128'(1));
        drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_empty(0, "t5.rel");

        // Random traffic against a queue model
        rand_phase(0, 600);
        rand_phase(1, 600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
